blob_tracker_multi: RTL

// Streaming per-channel blob tracker: successor to the single-mask centroid + edge-scan pair in the camera pipeline.

---
 rtl/blob_tracker_multi.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/blob_tracker_multi.sv
// blob_tracker_multi: single-pass per-channel centroid, pixel count and bounding box tracker.
// At frame end each channel is divided out sequentially and emitted as one valid/ready record.
// Optional feature macro: BLOB_TRACKER_SMOOTH_EN adds a per-channel IIR, out = (3*prev + new) >> 2, to the centroid.
module blob_tracker_multi #(
   parameter int CHANNELS  = 2,
   parameter int H_W       = 11,
   parameter int V_W       = 10,
   parameter int MAX_PIX   = 786432,
   parameter int MIN_COUNT = 16,
   localparam int CNT_W    = $clog2(MAX_PIX + 1),
   localparam int CH_W     = $clog2(CHANNELS) + 1
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [H_W-1:0]      x_in,
   input  logic [V_W-1:0]      y_in,
   input  logic [CHANNELS-1:0] valid_in,
   input  logic                tabulate_in,
   input  logic                ready_in,
   output logic                valid_out,
   output logic [CH_W-1:0]     ch_out,
   output logic [H_W-1:0]      x_out,
   output logic [V_W-1:0]      y_out,
   output logic [H_W-1:0]      left_out,
   output logic [H_W-1:0]      right_out,
   output logic [V_W-1:0]      top_out,
   output logic [V_W-1:0]      bot_out,
   output logic [CNT_W-1:0]    count_out,
   output logic                empty_out,
   output logic                busy_out,
   output logic                overrun_out
);
   localparam int SX_W = H_W + CNT_W;
   localparam int SY_W = V_W + CNT_W;
   localparam int D_W  = (SX_W > SY_W) ? SX_W : SY_W;
   localparam int K_W  = $clog2(D_W + 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, DIV_Y, EMIT} state_t;
   state_t state, state_nxt;

   logic [SX_W-1:0]  sx    [CHANNELS], nsx   [CHANNELS], ssx   [CHANNELS];
   logic [SY_W-1:0]  sy    [CHANNELS], nsy   [CHANNELS], ssy   [CHANNELS];
   logic [CNT_W-1:0] cnt   [CHANNELS], ncnt  [CHANNELS], scnt  [CHANNELS];
   logic [H_W-1:0]   minx  [CHANNELS], nminx [CHANNELS], sminx [CHANNELS];
   logic [H_W-1:0]   maxx  [CHANNELS], nmaxx [CHANNELS], smaxx [CHANNELS];
   logic [V_W-1:0]   miny  [CHANNELS], nminy [CHANNELS], sminy [CHANNELS];
   logic [V_W-1:0]   maxy  [CHANNELS], nmaxy [CHANNELS], smaxy [CHANNELS];

   logic [CH_W-1:0]  cidx, nidx;
   logic [SX_W-1:0]  ld_sx;
   logic [SY_W-1:0]  ld_sy;
   logic [CNT_W-1:0] ld_cnt;
   logic [H_W-1:0]   ld_minx, ld_maxx;
   logic [V_W-1:0]   ld_miny, ld_maxy;
   logic             ld_empty, load, x_last, y_last;

   logic [D_W-1:0]   q, q_nxt;
   logic [CNT_W-1:0] rem, rem_nxt, div_d;
   logic [CNT_W:0]   rem_sh;
   logic             ge;
   logic [K_W-1:0]   k;
   logic [SY_W-1:0]  hold_sy;
   logic [H_W-1:0]   x_raw, fin_x, empty_x;
   logic [V_W-1:0]   fin_y, empty_y;

   assign valid_out = (state == EMIT);
   assign busy_out  = (state != IDLE);
   assign ch_out    = cidx;

   // Live accumulator update for the current pixel; count saturation also freezes the sums.
   always_comb begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         nsx[c]   = sx[c];
         nsy[c]   = sy[c];
         ncnt[c]  = cnt[c];
         nminx[c] = minx[c];
         nmaxx[c] = maxx[c];
         nminy[c] = miny[c];
         nmaxy[c] = maxy[c];
         if (valid_in[c]) begin
            if (cnt[c] != CNT_W'(MAX_PIX)) begin
               nsx[c]  = sx[c] + SX_W'(x_in);
               nsy[c]  = sy[c] + SY_W'(y_in);
               ncnt[c] = cnt[c] + CNT_W'(1);
            end
            if (x_in < minx[c]) nminx[c] = x_in;
            if (x_in > maxx[c]) nmaxx[c] = x_in;
            if (y_in < miny[c]) nminy[c] = y_in;
            if (y_in > maxy[c]) nmaxy[c] = y_in;
         end
      end
   end

   // Live accumulators; any frame-end strobe clears them, busy or not.
   always_ff @(posedge clk_in) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (rst_in || tabulate_in) begin
            sx[c]   <= '0;
            sy[c]   <= '0;
            cnt[c]  <= '0;
            minx[c] <= '1;
            maxx[c] <= '0;
            miny[c] <= '1;
            maxy[c] <= '0;
         end else begin
            sx[c]   <= nsx[c];
            sy[c]   <= nsy[c];
            cnt[c]  <= ncnt[c];
            minx[c] <= nminx[c];
            maxx[c] <= nmaxx[c];
            miny[c] <= nminy[c];
            maxy[c] <= nmaxy[c];
         end
      end
   end

   // Frame snapshot, taken only from IDLE and including the pixel on the strobe cycle.
   always_ff @(posedge clk_in) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (rst_in) begin
            ssx[c]   <= '0;
            ssy[c]   <= '0;
            scnt[c]  <= '0;
            sminx[c] <= '0;
            smaxx[c] <= '0;
            sminy[c] <= '0;
            smaxy[c] <= '0;
         end else if (tabulate_in && state == IDLE) begin
            ssx[c]   <= nsx[c];
            ssy[c]   <= nsy[c];
            scnt[c]  <= ncnt[c];
            sminx[c] <= nminx[c];
            smaxx[c] <= nmaxx[c];
            sminy[c] <= nminy[c];
            smaxy[c] <= nmaxy[c];
         end
      end
   end

   // Operand select for the next channel; channel 0 comes straight from the live values
   // because the snapshot is being written on the same edge.
   always_comb begin
      nidx    = (state == IDLE) ? '0 : cidx + CH_W'(1);
      ld_sx   = '0;
      ld_sy   = '0;
      ld_cnt  = '0;
      ld_minx = '0;
      ld_maxx = '0;
      ld_miny = '0;
      ld_maxy = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (nidx == CH_W'(i)) begin
            if (state == IDLE) begin
               ld_sx   = nsx[i];
               ld_sy   = nsy[i];
               ld_cnt  = ncnt[i];
               ld_minx = nminx[i];
               ld_maxx = nmaxx[i];
               ld_miny = nminy[i];
               ld_maxy = nmaxy[i];
            end else begin
               ld_sx   = ssx[i];
               ld_sy   = ssy[i];
               ld_cnt  = scnt[i];
               ld_minx = sminx[i];
               ld_maxx = smaxx[i];
               ld_miny = sminy[i];
               ld_maxy = smaxy[i];
            end
         end
      end
      ld_empty = (ld_cnt < CNT_W'(MIN_COUNT));
   end

   // One restoring-division step; the dividend is left-aligned so the quotient fills q from the bottom.
   always_comb begin
      rem_sh  = {rem, q[D_W-1]};
      ge      = (rem_sh >= {1'b0, div_d});
      rem_nxt = ge ? CNT_W'(rem_sh - {1'b0, div_d}) : rem_sh[CNT_W-1:0];
      q_nxt   = {q[D_W-2:0], ge};
      x_last  = (state == DIVIDE) && (k == K_W'(SX_W - 1));
      y_last  = (state == DIV_Y) && (k == K_W'(SY_W - 1));
   end

`ifdef BLOB_TRACKER_SMOOTH_EN
   logic [H_W-1:0] prev_x [CHANNELS];
   logic [V_W-1:0] prev_y [CHANNELS];
   logic [H_W-1:0] cur_px;
   logic [V_W-1:0] cur_py;
   logic [H_W+1:0] sum_x;
   logic [V_W+1:0] sum_y;

   // IIR blend against the channel's previous centroid; empty records replay the history.
   always_comb begin
      cur_px  = '0;
      cur_py  = '0;
      empty_x = '0;
      empty_y = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (cidx == CH_W'(i)) begin
            cur_px = prev_x[i];
            cur_py = prev_y[i];
         end
         if (nidx == CH_W'(i)) begin
            empty_x = prev_x[i];
            empty_y = prev_y[i];
         end
      end
      sum_x = ({2'b00, cur_px} << 1) + {2'b00, cur_px} + {2'b00, x_raw};
      sum_y = ({2'b00, cur_py} << 1) + {2'b00, cur_py} + {2'b00, q_nxt[V_W-1:0]};
      fin_x = H_W'(sum_x >> 2);
      fin_y = V_W'(sum_y >> 2);
   end

   // History registers advance only when a non-empty record completes.
   always_ff @(posedge clk_in) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (rst_in) begin
            prev_x[c] <= '0;
            prev_y[c] <= '0;
         end else if (y_last && cidx == CH_W'(c)) begin
            prev_x[c] <= fin_x;
            prev_y[c] <= fin_y;
         end
      end
   end
`else
   // Raw centroid straight from the divider; empty records report zero.
   always_comb begin
      fin_x   = x_raw;
      fin_y   = q_nxt[V_W-1:0];
      empty_x = '0;
      empty_y = '0;
   end
`endif

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state; an empty channel skips both divides and goes straight to EMIT.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE:    if (tabulate_in) load = 1'b1;
         DIVIDE:  if (x_last) state_nxt = DIV_Y;
         DIV_Y:   if (y_last) state_nxt = EMIT;
         EMIT: begin
            if (ready_in) begin
               if (cidx == CH_W'(CHANNELS - 1)) state_nxt = IDLE;
               else                             load      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (load) state_nxt = ld_empty ? EMIT : DIVIDE;
   end

   // Divider sequencing and record registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         q           <= '0;
         rem         <= '0;
         div_d       <= '0;
         k           <= '0;
         hold_sy     <= '0;
         cidx        <= '0;
         x_raw       <= '0;
         x_out       <= '0;
         y_out       <= '0;
         left_out    <= '0;
         right_out   <= '0;
         top_out     <= '0;
         bot_out     <= '0;
         count_out   <= '0;
         empty_out   <= 1'b0;
         overrun_out <= 1'b0;
      end else begin
         overrun_out <= tabulate_in && (state != IDLE);
         if (state == DIVIDE || state == DIV_Y) begin
            q   <= q_nxt;
            rem <= rem_nxt;
            k   <= k + K_W'(1);
            if (x_last) begin
               x_raw <= q_nxt[H_W-1:0];
               q     <= D_W'(hold_sy) << (D_W - SY_W);
               rem   <= '0;
               k     <= '0;
            end
            if (y_last) begin
               x_out <= fin_x;
               y_out <= fin_y;
            end
         end
         if (load) begin
            cidx      <= nidx;
            q         <= D_W'(ld_sx) << (D_W - SX_W);
            rem       <= '0;
            k         <= '0;
            div_d     <= ld_cnt;
            hold_sy   <= ld_sy;
            count_out <= ld_cnt;
            empty_out <= ld_empty;
            if (ld_empty) begin
               x_out     <= empty_x;
               y_out     <= empty_y;
               left_out  <= '0;
               right_out <= '0;
               top_out   <= '0;
               bot_out   <= '0;
            end else begin
               left_out  <= ld_minx;
               right_out <= ld_maxx;
               top_out   <= ld_miny;
               bot_out   <= ld_maxy;
            end
         end
      end
   end
endmodule
